// File: rtl/spi_ciphertext_receiver.sv
// SPI slave that deserialises chip-select framed words into a small output FIFO,
// tagging each word with its position inside a WORDS_PER_NUM-word ciphertext.
// Latency: 4 clk_in cycles from chip select rising at the pin to data_valid_out.
// Backpressure: data_ready_in pops the FIFO; a good word arriving while full is
// dropped and overflow_out latches.

// Generic synchronous FIFO: power-of-two depth, registered storage.
// Latency: a push is visible at the head on the next cycle when empty.
// Backpressure: wr_rdy_o is high when not full or when a pop happens this cycle.
module spi_ct_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             wr_rdy_o,
    output logic             rd_vld_o,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_vld_o = ~empty;
    assign pop      = rd_vld_o & rd_rdy_i;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign wr_rdy_o = ~full | pop;
    assign push     = wr_vld_i & wr_rdy_o;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update and storage write; storage cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

module spi_ciphertext_receiver #(
    parameter int DATA_WIDTH    = 32,
    parameter int WORDS_PER_NUM = 128,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             chip_data_in,
    input  logic                             chip_clk_in,
    input  logic                             chip_sel_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_valid_out,
    input  logic                             data_ready_in,
    output logic                             data_last_out,
    output logic [$clog2(WORDS_PER_NUM)-1:0] word_index_out,
    output logic                             frame_error_out,
    output logic                             overflow_out
);
    localparam int IDX_W   = $clog2(WORDS_PER_NUM);
    localparam int CNT_W   = $clog2(DATA_WIDTH + 2);
    localparam int ENTRY_W = DATA_WIDTH + IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_NUM - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Synchronizer chains; *_prev_q holds the last synchronized value for edge detection.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q,   cs_sync_q,   cs_prev_q;
    logic sdi_meta_q,  sdi_sync_q;
    logic [1:0] settle_q;

    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [IDX_W-1:0]      index_q,   index_d;
    logic                  overflow_q, overflow_d;

    logic sclk_rise;
    logic cs_rise;
    logic cs_fall;
    logic settled;
    logic good_word;
    logic bad_word;
    logic drop_word;

    logic               fifo_wr_rdy;
    logic [ENTRY_W-1:0] fifo_wr_dat;
    logic [ENTRY_W-1:0] fifo_rd_dat;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_sync_q;
    // The cs chain resets high, so it only reflects the pin two cycles after reset.
    assign settled   = (settle_q == 2'd2);

    // Bring the SPI pins into the clk_in domain and remember previous values for edges.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            sclk_meta_q <= chip_clk_in;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= chip_sel_in;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sdi_meta_q  <= chip_data_in;
            sdi_sync_q  <= sdi_meta_q;
            if (!settled) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a frame in progress at reset release is skipped by WAIT_IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (settled && cs_sync_q) state_d = IDLE;
            IDLE:      if (cs_fall)              state_d = SHIFT;
            SHIFT:     if (cs_rise)              state_d = COMMIT;
            COMMIT:                              state_d = IDLE;
            default:                             state_d = WAIT_IDLE;
        endcase
    end

    // FSM outputs: classify the frame in COMMIT and decide push / drop / error.
    always_comb begin
        good_word = 1'b0;
        bad_word  = 1'b0;
        if (state_q == COMMIT) begin
            good_word = (bit_cnt_q == CNT_FULL);
            bad_word  = (bit_cnt_q != CNT_FULL);
        end
        drop_word = good_word & ~fifo_wr_rdy;
    end

    // Datapath next-state: bit counting, shifting, ciphertext index and overflow flag.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        index_d    = index_q;
        overflow_d = overflow_q | drop_word;
        if (state_q == IDLE && cs_fall) begin
            bit_cnt_d = '0;
        end else if (state_q == SHIFT && sclk_rise) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], sdi_sync_q};
            if (bit_cnt_q != CNT_SAT) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        // Dropped good words still advance the index to keep ciphertext alignment.
        if (good_word) begin
            index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            index_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            index_q    <= index_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_wr_dat = {(index_q == IDX_LAST), index_q, shift_q};

    spi_ct_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_in),
        .rst_ni   (rst_in),
        .wr_vld_i (good_word),
        .wr_dat_i (fifo_wr_dat),
        .wr_rdy_o (fifo_wr_rdy),
        .rd_vld_o (data_valid_out),
        .rd_rdy_i (data_ready_in),
        .rd_dat_o (fifo_rd_dat)
    );

    assign data_out        = fifo_rd_dat[DATA_WIDTH-1:0];
    assign word_index_out  = fifo_rd_dat[DATA_WIDTH +: IDX_W];
    assign data_last_out   = fifo_rd_dat[ENTRY_W-1];
    assign frame_error_out = bad_word;
    assign overflow_out    = overflow_q;
endmodule

// File: tb/tb_spi_ciphertext_receiver.sv
// Scoreboard bench for spi_ciphertext_receiver: directed SPI frames push expected
// words into a queue, a negedge monitor pops and compares every accepted output.
// Frame errors are counted by the monitor and checked as deltas per scenario.
module tb_spi_ciphertext_receiver;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        chip_data_in = 1'b0;
    logic        chip_clk_in = 1'b0;
    logic        chip_sel_in = 1'b1;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        data_ready_in = 1'b0;
    logic        data_last_out;
    logic [6:0]  word_index_out;
    logic        frame_error_out;
    logic        overflow_out;

    typedef struct {
        logic [31:0] dat;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   exp_idx = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   err_pulses = 0;

    spi_ciphertext_receiver #(
        .DATA_WIDTH    (32),
        .WORDS_PER_NUM (128),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .chip_data_in    (chip_data_in),
        .chip_clk_in     (chip_clk_in),
        .chip_sel_in     (chip_sel_in),
        .data_out        (data_out),
        .data_valid_out  (data_valid_out),
        .data_ready_in   (data_ready_in),
        .data_last_out   (data_last_out),
        .word_index_out  (word_index_out),
        .frame_error_out (frame_error_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: count error pulses and compare every accepted word with the scoreboard.
    always @(negedge clk_in) begin
        if (rst_in && frame_error_out) err_pulses++;
        if (rst_in && data_valid_out && data_ready_in) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got 0x%0h, expected no output", data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", 64'(data_out), 64'(e.dat));
                check("word_index", 64'(word_index_out), 64'(e.idx));
                check("data_last", 64'(data_last_out), 64'(e.last));
            end
        end
    end

    // Reference model: record an accepted word, or just advance the index on a drop.
    task automatic expect_word(input logic [31:0] w);
        exp_t e;
        e.dat  = w;
        e.idx  = 7'(exp_idx);
        e.last = (exp_idx == 127);
        exp_q.push_back(e);
        exp_idx = (exp_idx + 1) % 128;
    endtask

    task automatic expect_drop();
        exp_idx = (exp_idx + 1) % 128;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic frame_bits(input logic [63:0] v, input int n, input int hp);
        for (int i = n - 1; i >= 0; i--) begin
            chip_data_in = v[i];
            tick(hp);
            chip_clk_in = 1'b1;
            tick(hp);
            chip_clk_in = 1'b0;
        end
    endtask

    task automatic send(input logic [63:0] v, input int n, input int hp);
        chip_sel_in = 1'b0;
        tick(hp);
        frame_bits(v, n, hp);
        tick(hp);
        chip_sel_in = 1'b1;
        tick(12);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick(2);
        check("rst_valid", 64'(data_valid_out), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_last", 64'(data_last_out), 64'd0);
        check("rst_index", 64'(word_index_out), 64'd0);
        check("rst_frame_err", 64'(frame_error_out), 64'd0);
        check("rst_overflow", 64'(overflow_out), 64'd0);
        exp_q.delete();
        exp_idx = 0;
        rst_in = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        tick(4);
        check(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int base;

        // Single frame at a 100-cycle SCLK period, with latency probe.
        do_reset();
        tick(6);
        data_ready_in = 1'b1;
        base = err_pulses;
        expect_word(32'hDEADBEEF);
        chip_sel_in = 1'b0;
        tick(50);
        frame_bits(64'hDEADBEEF, 32, 50);
        tick(50);
        chip_sel_in = 1'b1;
        tick(3);
        check("latency_valid_early", 64'(data_valid_out), 64'd0);
        tick(1);
        check("latency_valid_at4", 64'(data_valid_out), 64'd1);
        tick(12);
        wait_drain("drain_single");
        check("single_no_error", 64'(err_pulses - base), 64'd0);

        // Full ciphertext plus one wrap-around word.
        do_reset();
        tick(6);
        data_ready_in = 1'b1;
        for (int i = 0; i < 129; i++) begin
            expect_word(32'(i));
            send(64'(i), 32, 4);
        end
        wait_drain("drain_cipher");

        // Malformed frames around a good one.
        do_reset();
        tick(6);
        base = err_pulses;
        send(64'h7FFF_FFFF, 31, 10);
        send(64'h1_FFFF_FFFF, 33, 10);
        expect_word(32'h12345678);
        send(64'h12345678, 32, 10);
        wait_drain("drain_malformed");
        check("malformed_err_pulses", 64'(err_pulses - base), 64'd2);
        check("malformed_no_overflow", 64'(overflow_out), 64'd0);

        // Backpressure: four buffered, two dropped, index keeps advancing.
        do_reset();
        tick(6);
        data_ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_word(32'hA000_0000 + 32'(i));
            else       expect_drop();
            send(64'(32'hA000_0000 + 32'(i)), 32, 10);
            if (i == 3) check("bp_no_overflow_yet", 64'(overflow_out), 64'd0);
        end
        check("bp_overflow_set", 64'(overflow_out), 64'd1);
        check("bp_valid_held", 64'(data_valid_out), 64'd1);
        data_ready_in = 1'b1;
        wait_drain("drain_bp");
        expect_word(32'hA000_0006);
        send(64'hA000_0006, 32, 10);
        wait_drain("drain_bp_next");
        check("bp_overflow_sticky", 64'(overflow_out), 64'd1);

        // Reset in the middle of a frame, released while chip select is still low.
        do_reset();
        tick(6);
        data_ready_in = 1'b1;
        base = err_pulses;
        chip_sel_in = 1'b0;
        tick(10);
        frame_bits(64'h1111, 16, 10);
        do_reset();
        frame_bits(64'h2222, 16, 10);
        tick(10);
        chip_sel_in = 1'b1;
        tick(12);
        expect_word(32'hCAFEF00D);
        send(64'hCAFEF00D, 32, 10);
        wait_drain("drain_midreset");
        check("midreset_no_error", 64'(err_pulses - base), 64'd0);

        // Full FIFO with a pop exactly on the COMMIT cycle of the next word.
        do_reset();
        tick(6);
        data_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_word(32'hB000_0000 + 32'(i));
            send(64'(32'hB000_0000 + 32'(i)), 32, 10);
        end
        expect_word(32'hB000_0004);
        chip_sel_in = 1'b0;
        tick(10);
        frame_bits(64'hB000_0004, 32, 10);
        tick(10);
        chip_sel_in = 1'b1;
        tick(3);
        data_ready_in = 1'b1;
        tick(1);
        data_ready_in = 1'b0;
        tick(8);
        check("full_pushpop_no_overflow", 64'(overflow_out), 64'd0);
        data_ready_in = 1'b1;
        wait_drain("drain_full");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
